rolling_variance: RTL and testbench

//  Upstream feeder for the fixed-point square-root stage in the volatility path.

---
 rtl/hft_stats_pkg.sv | 21 ++
 rtl/sample_ring.sv | 31 +++
 rtl/rolling_variance.sv | 141 ++++++++++++++
 tb/tb_rolling_variance.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hft_stats_pkg.sv
// Shared types and width helpers for the rolling-variance volatility feeder.
package hft_stats_pkg;

    typedef enum logic [1:0] {IDLE, UPD, VAR, ISSUE} rollvar_state_t;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_FRACT_BITS = 0;
    localparam int unsigned DEF_LOG2_WIN   = 2;

    localparam int unsigned SUM_W = DEF_WIDTH + DEF_LOG2_WIN;
    localparam int unsigned SQ_W  = 2 * DEF_WIDTH + DEF_LOG2_WIN;

    function automatic int unsigned sum_w(input int unsigned width, input int unsigned log2_win);
        return width + log2_win;
    endfunction

    function automatic int unsigned sq_w(input int unsigned width, input int unsigned log2_win);
        return 2 * width + log2_win;
    endfunction

endpackage

// File: rtl/sample_ring.sv
// Sliding-window sample store: combinational read at the write pointer, write advances it.
module sample_ring #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOG2_WIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** LOG2_WIN;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [LOG2_WIN-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
        end else if (wr_en) begin
            mem_q[ptr_q] <= wr_data;
            ptr_q        <= ptr_q + LOG2_WIN'(1);
        end
    end

    // Slot about to be overwritten holds the oldest sample.
    assign rd_data = mem_q[ptr_q];

endmodule

// File: rtl/rolling_variance.sv
// Windowed variance feeder for the square-root stage (output is the windowed std-dev).
// Optional stall-cycle counter port enabled by ROLLVAR_STALL_CNT_EN.
module rolling_variance
    import hft_stats_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned FRACT_BITS = DEF_FRACT_BITS,
    parameter int unsigned LOG2_WIN   = DEF_LOG2_WIN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_sample,
    output logic             o_ready,
    output logic             o_sqrt_start,
    output logic [WIDTH-1:0] o_rad,
    input  logic             i_sqrt_busy,
`ifdef ROLLVAR_STALL_CNT_EN
    output logic             o_warm,
    output logic [15:0]      o_stall_cnt
`else
    output logic             o_warm
`endif
);

    localparam int unsigned ACC_W  = sum_w(WIDTH, LOG2_WIN);
    localparam int unsigned SQA_W  = sq_w(WIDTH, LOG2_WIN);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned VAR_W  = 2 * WIDTH + 1;
    localparam int unsigned FILL_W = LOG2_WIN + 1;
    localparam int unsigned WINDOW = 2 ** LOG2_WIN;

    rollvar_state_t state_q, state_d;
    logic accept, ring_wr, var_ld, issue;

    logic [WIDTH-1:0]  new_q, old_sample, rad_next_q, rad_q;
    logic [ACC_W-1:0]  sum_q;
    logic [SQA_W-1:0]  sumsq_q;
    logic [FILL_W-1:0] fill_q;
    logic              warm_q;

    sample_ring #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) u_ring (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (ring_wr),
        .wr_data (new_q),
        .rd_data (old_sample)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ring_wr = 1'b0;
        var_ld  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (i_valid) begin
                accept  = 1'b1;
                state_d = UPD;
            end
            UPD: begin
                ring_wr = 1'b1;
                state_d = VAR;
            end
            VAR: begin
                var_ld  = 1'b1;
                state_d = warm_q ? ISSUE : IDLE;
            end
            ISSUE: if (!i_sqrt_busy) begin
                issue   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Squares of incoming and evicted samples for the sum-of-squares update.
    logic [PROD_W-1:0] new_sqr, old_sqr;
    assign new_sqr = PROD_W'(new_q) * PROD_W'(new_q);
    assign old_sqr = PROD_W'(old_sample) * PROD_W'(old_sample);

    // Variance datapath; a negative result only comes from truncating the means.
    logic [WIDTH-1:0]         mean;
    logic [PROD_W-1:0]        msq, mean_sq;
    logic signed [VAR_W-1:0]  v;
    logic [VAR_W-1:0]         v_pos, rad_wide;
    logic [WIDTH-1:0]         rad_sat;

    assign mean     = WIDTH'(sum_q >> LOG2_WIN);
    assign msq      = PROD_W'(sumsq_q >> LOG2_WIN);
    assign mean_sq  = PROD_W'(mean) * PROD_W'(mean);
    assign v        = $signed({1'b0, msq}) - $signed({1'b0, mean_sq});
    assign v_pos    = v[VAR_W-1] ? '0 : VAR_W'(v);
    assign rad_wide = v_pos >> FRACT_BITS;
    assign rad_sat  = (|rad_wide[VAR_W-1:WIDTH]) ? '1 : rad_wide[WIDTH-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            new_q      <= '0;
            sum_q      <= '0;
            sumsq_q    <= '0;
            fill_q     <= '0;
            warm_q     <= 1'b0;
            rad_next_q <= '0;
            rad_q      <= '0;
        end else begin
            if (accept) new_q <= i_sample;
            if (ring_wr) begin
                sum_q   <= sum_q + ACC_W'(new_q) - ACC_W'(old_sample);
                sumsq_q <= sumsq_q + SQA_W'(new_sqr) - SQA_W'(old_sqr);
                if (fill_q != FILL_W'(WINDOW)) fill_q <= fill_q + FILL_W'(1);
                if (fill_q == FILL_W'(WINDOW - 1)) warm_q <= 1'b1;
            end
            if (var_ld) rad_next_q <= rad_sat;
            if (issue)  rad_q      <= rad_next_q;
        end
    end

    // Radicand is presented during the start cycle and held until the next start.
    assign o_ready      = (state_q == IDLE);
    assign o_sqrt_start = issue;
    assign o_rad        = issue ? rad_next_q : rad_q;
    assign o_warm       = warm_q;

`ifdef ROLLVAR_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) stall_q <= '0;
        else if (i_valid && !o_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rolling_variance.sv
// Directed + randomized bench for rolling_variance against a window-average reference model.
module tb_rolling_variance;

    localparam int WINDOW = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic [7:0] i_sample;
    logic       o_ready;
    logic       o_sqrt_start;
    logic [7:0] o_rad;
    logic       i_sqrt_busy;
    logic       o_warm;
`ifdef ROLLVAR_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    rolling_variance #(.WIDTH(8), .FRACT_BITS(0), .LOG2_WIN(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_sample     (i_sample),
        .o_ready      (o_ready),
        .o_sqrt_start (o_sqrt_start),
        .o_rad        (o_rad),
        .i_sqrt_busy  (i_sqrt_busy),
`ifdef ROLLVAR_STALL_CNT_EN
        .o_warm       (o_warm),
        .o_stall_cnt  (o_stall_cnt)
`else
        .o_warm       (o_warm)
`endif
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;
    int win[$];
    int fill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        win  = {0, 0, 0, 0};
        fill = 0;
    endfunction

    function automatic void model_push(input int s);
        win.push_back(s);
        void'(win.pop_front());
        if (fill < WINDOW) fill++;
    endfunction

    // Population variance of the window using integer means, clamped to the radicand range.
    function automatic int model_rad();
        int sum = 0, sq = 0, mean, msq, v;
        foreach (win[i]) begin
            sum += win[i];
            sq  += win[i] * win[i];
        end
        mean = sum / WINDOW;
        msq  = sq / WINDOW;
        v    = msq - mean * mean;
        if (v < 0) v = 0;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic send(input int s, input int nbusy);
        int tmo = 0;
        int exp_rad;
        while (!o_ready && tmo < 20) begin
            @(posedge i_clk); #1;
            tmo++;
        end
        chk("ready_before_accept", 32'(o_ready), 32'd1);
        i_valid     = 1'b1;
        i_sample    = 8'(s);
        i_sqrt_busy = (nbusy > 0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        model_push(s);
        exp_rad = model_rad();
        chk("ready_upd", 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;
        chk("start_var", 32'(o_sqrt_start), 32'd0);
        @(posedge i_clk); #1;
        chk("warm", 32'(o_warm), 32'(fill == WINDOW));
        if (fill == WINDOW) begin
            for (int k = 0; k < nbusy; k++) begin
                chk("bp_start", 32'(o_sqrt_start), 32'd0);
                chk("bp_ready", 32'(o_ready), 32'd0);
                @(posedge i_clk); #1;
            end
            i_sqrt_busy = 1'b0;
            #1;
            chk("start", 32'(o_sqrt_start), 32'd1);
            chk("rad", 32'(o_rad), 32'(exp_rad));
            @(posedge i_clk); #1;
            chk("start_one_cycle", 32'(o_sqrt_start), 32'd0);
            chk("rad_hold", 32'(o_rad), 32'(exp_rad));
        end else begin
            chk("no_start_cold", 32'(o_sqrt_start), 32'd0);
            chk("ready_cold", 32'(o_ready), 32'd1);
        end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_sample    = '0;
        i_sqrt_busy = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_start", 32'(o_sqrt_start), 32'd0);
        chk("rst_rad", 32'(o_rad), 32'd0);
        chk("rst_warm", 32'(o_warm), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Warm-up with a flat window.
        for (int i = 0; i < 4; i++) send(4, 0);
        chk("warmup_rad", 32'(o_rad), 32'd0);

        // Alternating steady window.
        send(2, 0); send(6, 0); send(2, 0); send(6, 0);
        chk("steady_final_rad", 32'(o_rad), 32'd4);

        // Extreme swing saturates the radicand.
        send(0, 0); send(255, 0); send(0, 0); send(255, 0);
        chk("saturation_rad", 32'(o_rad), 32'd255);

        // Root stage busy for 10 cycles while a result waits.
        send(100, 10);

        // Reset while in VAR.
        i_valid  = 1'b1;
        i_sample = 8'd77;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_start", 32'(o_sqrt_start), 32'd0);
        chk("midrst_rad", 32'(o_rad), 32'd0);
        chk("midrst_warm", 32'(o_warm), 32'd0);
        model_reset();
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)), 0);
        send(int'($urandom_range(0, 255)), 0);

        // Random samples with random root-stage backpressure.
        for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

`ifdef ROLLVAR_STALL_CNT_EN
        // Continuous valid: 2 stalls per cold accept, 3 per warm accept.
        i_rst_n = 1'b0;
        #1;
        i_rst_n = 1'b1;
        model_reset();
        chk("stall_rst", 32'(o_stall_cnt), 32'd0);
        i_valid  = 1'b1;
        i_sample = 8'd9;
        repeat (29) @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        chk("stall_cnt", 32'(o_stall_cnt), 32'd21);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
